// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared types and constants for the serial FIR engine
// Contents: FSM state enum, tap count/address width, coefficient field index helpers.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam int TAPS           = 4;
  localparam int TAP_ADDR_WIDTH = 2;

  // Coefficient layout: top bit is the sign, everything below is magnitude.
  function automatic int coef_sign_idx(input int width);
    return width - 1;
  endfunction

  function automatic int coef_mag_msb(input int width);
    return width - 2;
  endfunction

endpackage

// File: rtl/fir_mac_engine_mac.sv
// rtl/fir_mac_engine_mac.sv - signed sample times sign-magnitude coefficient
// Ports:
//   i_sample  in   SAMPLE_WIDTH  two's-complement sample
//   i_coef    in   DATA_WIDTH    sign-magnitude coefficient
//   o_addend  out  ACC_WIDTH     signed product, negated when the coefficient sign is set
module sign_mag_mac
  import fir_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 12,
  parameter int DATA_WIDTH   = 12,
  parameter int ACC_WIDTH    = SAMPLE_WIDTH + DATA_WIDTH + 2
) (
  input  logic signed [SAMPLE_WIDTH-1:0] i_sample,
  input  logic        [DATA_WIDTH-1:0]   i_coef,
  output logic signed [ACC_WIDTH-1:0]    o_addend
);

  localparam int PROD_WIDTH = SAMPLE_WIDTH + DATA_WIDTH;
  localparam int SIGN_IDX   = coef_sign_idx(DATA_WIDTH);
  localparam int MAG_MSB    = coef_mag_msb(DATA_WIDTH);

  logic signed [DATA_WIDTH-1:0] w_mag;
  logic signed [PROD_WIDTH-1:0] w_prod;
  logic signed [ACC_WIDTH-1:0]  w_prod_ext;

  // Leading zero keeps the magnitude non-negative in the signed multiply.
  assign w_mag      = $signed({1'b0, i_coef[MAG_MSB:0]});
  assign w_prod     = PROD_WIDTH'(i_sample) * PROD_WIDTH'(w_mag);
  assign w_prod_ext = {{(ACC_WIDTH-PROD_WIDTH){w_prod[PROD_WIDTH-1]}}, w_prod};

  // Negative zero gives -0 == 0, so it needs no special case.
  assign o_addend   = i_coef[SIGN_IDX] ? -w_prod_ext : w_prod_ext;

endmodule

// File: rtl/fir_mac_engine.sv
// rtl/fir_mac_engine.sv - serial 4-tap FIR, one multiply-accumulate per cycle
// Ports:
//   clk, rst       in   clock, asynchronous active-high reset
//   in_valid       in   sample offered
//   in_ready       out  engine idle and able to take a sample
//   in_data        in   SAMPLE_WIDTH signed sample
//   rom_r_address  out  coefficient ROM tap address (0 outside MAC)
//   rom_r_data     in   coefficient for rom_r_address, combinational
//   out_valid      out  result held in out_data
//   out_ready      in   sink takes result
//   out_data       out  ACC_WIDTH signed result
module fir_mac_engine
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH   = 12,
  parameter int SAMPLE_WIDTH = 12,
  parameter int ACC_WIDTH    = SAMPLE_WIDTH + DATA_WIDTH + 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SAMPLE_WIDTH-1:0]   in_data,
  output logic [TAP_ADDR_WIDTH-1:0] rom_r_address,
  input  logic [DATA_WIDTH-1:0]     rom_r_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACC_WIDTH-1:0]      out_data
);

  localparam logic [TAP_ADDR_WIDTH-1:0] LAST_TAP = TAP_ADDR_WIDTH'(TAPS - 1);

  state_t                          r_state;
  state_t                          w_next_state;
  logic [TAP_ADDR_WIDTH-1:0]       r_tap;
  logic signed [SAMPLE_WIDTH-1:0]  r_x [TAPS];
  logic signed [ACC_WIDTH-1:0]     r_acc;
  logic signed [ACC_WIDTH-1:0]     r_out_data;
  logic signed [ACC_WIDTH-1:0]     w_addend;
  logic signed [ACC_WIDTH-1:0]     w_acc_sum;
  logic                            w_accept;

  sign_mag_mac #(
    .SAMPLE_WIDTH (SAMPLE_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH),
    .ACC_WIDTH    (ACC_WIDTH)
  ) u_mac (
    .i_sample (r_x[r_tap]),
    .i_coef   (rom_r_data),
    .o_addend (w_addend)
  );

  assign w_acc_sum = r_acc + w_addend;

  // Handshake outputs are pure state decodes: no input-to-output paths.
  assign in_ready      = (r_state == IDLE);
  assign out_valid     = (r_state == OUT);
  assign rom_r_address = (r_state == MAC) ? r_tap : '0;
  assign out_data      = r_out_data;
  assign w_accept      = in_ready && in_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (in_valid)          w_next_state = MAC;
      MAC:     if (r_tap == LAST_TAP) w_next_state = OUT;
      OUT:     if (out_ready)         w_next_state = IDLE;
      default:                        w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tap      <= '0;
      r_acc      <= '0;
      r_out_data <= '0;
      for (int k = 0; k < TAPS; k++) begin
        r_x[k] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_x[0] <= $signed(in_data);
        for (int k = 1; k < TAPS; k++) begin
          r_x[k] <= r_x[k-1];
        end
        r_acc <= '0;
        r_tap <= '0;
      end else if (r_state == MAC) begin
        r_acc <= w_acc_sum;
        r_tap <= r_tap + 1'b1;
        // Last tap: capture the complete sum directly, bypassing r_acc.
        if (r_tap == LAST_TAP) begin
          r_out_data <= w_acc_sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_mac_engine.sv
// tb/tb_fir_mac_engine.sv - self-checking bench for fir_mac_engine with scoreboard
module tb_fir_mac_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] in_data = '0;
  logic [1:0]  rom_r_address;
  logic [11:0] rom_r_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [25:0] out_data;

  int checks = 0;
  int failures = 0;
  int accepts = 0;
  int mx [4];
  int exp_q [$];
  int coef [4] = '{1024, -1536, 320, -1920};

  always #5 clk = ~clk;

  fir_mac_engine dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .rom_r_address (rom_r_address),
    .rom_r_data    (rom_r_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data)
  );

  // Coefficient ROM: +0.5, -0.75, +0.15625, -0.9375 in sign-magnitude.
  always_comb begin
    rom_r_data = 12'h000;
    case (rom_r_address)
      2'd0: rom_r_data = 12'h400;
      2'd1: rom_r_data = 12'hE00;
      2'd2: rom_r_data = 12'h140;
      2'd3: rom_r_data = 12'hF80;
      default: rom_r_data = 12'h000;
    endcase
  end

  // Scoreboard producer: model the delay line on every accepted sample.
  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) mx[k] = 0;
      exp_q.delete();
    end else if (in_valid && in_ready) begin
      int s;
      int sv;
      sv = $signed(in_data);
      for (int k = 3; k > 0; k--) mx[k] = mx[k-1];
      mx[0] = sv;
      s = 0;
      for (int k = 0; k < 4; k++) s += coef[k] * mx[k];
      exp_q.push_back(s);
      accepts++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic feed(input int v);
    int n;
    n = 0;
    in_data  = 12'(v);
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 40) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (!in_ready) begin
      failures++;
      $display("FAIL feed_accept got in_ready=%0b want 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    bit ok;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++;
    if (out_data !== 26'd0) begin failures++; $display("FAIL reset_out_data got %0d want 0", $signed(out_data)); end
    out_ready = 1'b0;
    feed(123);
    wait_out(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL reset_pre_out got timeout want out_valid"); end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL async_rst_out_valid got %0b want 0", out_valid); end
    checks++;
    if (out_data !== 26'd0) begin failures++; $display("FAIL async_rst_out_data got %0d want 0", $signed(out_data)); end
    checks++;
    if (rom_r_address !== 2'd0) begin failures++; $display("FAIL async_rst_addr got %0d want 0", rom_r_address); end
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_release_in_ready got %0b want 1", in_ready); end
  endtask

  task automatic test_impulse;
    int vals [4] = '{1000, 0, 0, 0};
    int req  [4] = '{1024000, -1536000, 320000, -1920000};
    bit ok;
    int got;
    int e;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      feed(vals[i]);
      wait_out(ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL impulse_timeout[%0d] got no out_valid want out_valid", i);
      end else begin
        got = $signed(out_data);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'h7fffffff;
        checks++;
        if (got !== e) begin failures++; $display("FAIL impulse_sb[%0d] got %0d want %0d", i, got, e); end
        checks++;
        if (got !== req[i]) begin failures++; $display("FAIL impulse_value[%0d] got %0d want %0d", i, got, req[i]); end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_full_scale;
    bit ok;
    int got;
    int e;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      feed(-2048);
      wait_out(ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL fullscale_timeout[%0d] got no out_valid want out_valid", i);
      end else begin
        got = $signed(out_data);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'h7fffffff;
        checks++;
        if (got !== e) begin failures++; $display("FAIL fullscale_sb[%0d] got %0d want %0d", i, got, e); end
        if (i == 3) begin
          checks++;
          if (got !== 4325376) begin failures++; $display("FAIL fullscale_value got %0d want 4325376", got); end
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_backpressure;
    bit ok;
    int got;
    int e;
    logic [25:0] d0;
    int acc0;
    out_ready = 1'b0;
    feed(300);
    wait_out(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL bp_timeout got no out_valid want out_valid"); end
    d0 = out_data;
    acc0 = accepts;
    @(posedge clk);
    #1;
    in_data  = 12'(-77);
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid[%0d] got %0b want 1", c, out_valid); end
      checks++;
      if (out_data !== d0) begin failures++; $display("FAIL bp_out_data[%0d] got %0d want %0d", c, $signed(out_data), $signed(d0)); end
      checks++;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready[%0d] got %0b want 0", c, in_ready); end
    end
    checks++;
    if (accepts !== acc0) begin failures++; $display("FAIL bp_no_consume got %0d accepts want %0d", accepts, acc0); end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    got = $signed(out_data);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'h7fffffff;
    checks++;
    if (got !== e) begin failures++; $display("FAIL bp_first_sb got %0d want %0d", got, e); end
    @(posedge clk);
    #1;
    feed(-77);
    wait_out(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL bp_second_timeout got no out_valid want out_valid");
    end else begin
      got = $signed(out_data);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'h7fffffff;
      checks++;
      if (got !== e) begin failures++; $display("FAIL bp_second_sb got %0d want %0d", got, e); end
    end
    checks++;
    if (accepts !== acc0 + 1) begin failures++; $display("FAIL bp_single_accept got %0d accepts want %0d", accepts, acc0 + 1); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_mac;
    bit ok;
    int got;
    int e;
    out_ready = 1'b1;
    feed(500);
    wait_out(ok);
    if (ok) void'(exp_q.pop_front());
    @(posedge clk);
    #1;
    feed(700);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checks++;
    if (rom_r_address !== 2'd2) begin failures++; $display("FAIL midmac_addr got %0d want 2", rom_r_address); end
    rst = 1'b1;
    #1;
    checks++;
    if (rom_r_address !== 2'd0) begin failures++; $display("FAIL midmac_rst_addr got %0d want 0", rom_r_address); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL midmac_rst_out_valid got %0b want 0", out_valid); end
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    feed(1000);
    wait_out(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL midmac_timeout got no out_valid want out_valid");
    end else begin
      got = $signed(out_data);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'h7fffffff;
      checks++;
      if (got !== e) begin failures++; $display("FAIL midmac_sb got %0d want %0d", got, e); end
      checks++;
      if (got !== 1024000) begin failures++; $display("FAIL midmac_value got %0d want 1024000", got); end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_throughput;
    int last_acc;
    int n;
    int accs;
    int pops;
    int got;
    int e;
    bit prev_ov;
    bit acc_now;
    last_acc = -1;
    n = 0;
    accs = 0;
    pops = 0;
    prev_ov = 1'b0;
    out_ready = 1'b1;
    in_data = 12'($urandom_range(4095));
    in_valid = 1'b1;
    while (pops < 4 && n < 80) begin
      @(negedge clk);
      acc_now = in_valid && in_ready;
      if (acc_now) begin
        if (last_acc >= 0) begin
          checks++;
          if (n - last_acc !== 6) begin failures++; $display("FAIL tp_interval got %0d want 6", n - last_acc); end
        end
        last_acc = n;
        accs++;
      end
      if (last_acc >= 0 && n - last_acc >= 1 && n - last_acc <= 4) begin
        checks++;
        if (rom_r_address !== 2'(n - last_acc - 1)) begin
          failures++;
          $display("FAIL tp_addr got %0d want %0d", rom_r_address, n - last_acc - 1);
        end
      end
      if (out_valid && !prev_ov) begin
        checks++;
        if (n - last_acc !== 5) begin failures++; $display("FAIL tp_latency got %0d negedges want 5", n - last_acc); end
      end
      if (out_valid) begin
        got = $signed(out_data);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'h7fffffff;
        checks++;
        if (got !== e) begin failures++; $display("FAIL tp_sb[%0d] got %0d want %0d", pops, got, e); end
        pops++;
      end
      prev_ov = out_valid;
      @(posedge clk);
      #1;
      if (acc_now) begin
        in_data = 12'($urandom_range(4095));
        if (accs == 4) in_valid = 1'b0;
      end
      n++;
    end
    in_valid = 1'b0;
    checks++;
    if (pops !== 4) begin failures++; $display("FAIL tp_outputs got %0d want 4", pops); end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_full_scale();
    test_backpressure();
    test_reset_mid_mac();
    test_throughput();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
